// File: rtl/dot_update_queue_pkg.sv
// Shared constants, decode kinds and helper functions for the dot update queue.
// The MMIO window maps one X word and one Y word per dot. Every dot has an
// id in 0..DOT_COUNT-1. Coordinates are clamped to the visible screen area.
package dot_update_queue_pkg;

    localparam int ID_W    = 10;
    localparam int LEVEL_W = 7;

    localparam logic [31:0] X_BASE    = 32'd100;
    localparam logic [31:0] Y_BASE    = 32'd550;
    localparam logic [31:0] MMIO_END  = 32'd999;
    localparam logic [31:0] DOT_COUNT = 32'd450;
    localparam logic [31:0] X_MAX     = 32'd639;
    localparam logic [31:0] Y_MAX     = 32'd479;

    typedef enum logic [1:0] {
        DEC_NONE = 2'd0,
        DEC_X    = 2'd1,
        DEC_Y    = 2'd2
    } dec_kind_e;

    // Classify a data-memory word address as an X write, a Y write, or neither.
    function automatic dec_kind_e decode_addr(input logic [31:0] addr);
        dec_kind_e kind;
        kind = DEC_NONE;
        if (addr >= X_BASE && addr <= (X_BASE + DOT_COUNT - 32'd1)) begin
            kind = DEC_X;
        end else if (addr >= Y_BASE && addr <= MMIO_END) begin
            kind = DEC_Y;
        end else begin
            kind = DEC_NONE;
        end
        return kind;
    endfunction

    // Unsigned 32-bit clamp. The caller truncates the result to the stored width.
    function automatic logic [31:0] clamp_coord(input logic [31:0] data,
                                                input logic [31:0] max_val);
        return (data > max_val) ? max_val : data;
    endfunction

endpackage

// File: rtl/dot_update_queue_fifo.sv
// dot_fifo: synchronous FIFO of DEPTH entries with a registered head.
// The head register holds the oldest entry. Entries behind the head sit in a
// circular array. A push into an empty FIFO lands in the head one cycle later,
// so there is no same-cycle bypass.
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   push, din    : write request and entry (dropped here when full and no pop)
//   pop          : consumer accepts the head (ignored while empty)
//   head         : oldest entry (registered)
//   level        : occupancy 0..DEPTH, including the head
//   full, empty  : registered occupancy flags
module dot_fifo
    import dot_update_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 21
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [W-1:0]       din,
    input  logic               pop,
    output logic [W-1:0]       head,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   mem_cnt_r;
    logic [LEVEL_W-1:0] level_r;
    logic [W-1:0]       head_r;
    logic               full_r;
    logic               empty_r;

    logic               pop_ok_s;
    logic               push_ok_s;
    logic               head_free_s;
    logic               load_mem_s;
    logic               load_din_s;
    logic               write_mem_s;
    logic [CNT_W-1:0]   mem_cnt_next_s;
    logic [LEVEL_W-1:0] level_next_s;

    // Per-cycle transfer decisions for the head register and the backing array.
    always_comb begin
        pop_ok_s       = pop && !empty_r;
        // When full, a push is accepted only if the head leaves in the same cycle.
        push_ok_s      = push && (!full_r || pop_ok_s);
        head_free_s    = empty_r || pop_ok_s;
        load_mem_s     = head_free_s && (mem_cnt_r != {CNT_W{1'b0}});
        load_din_s     = head_free_s && (mem_cnt_r == {CNT_W{1'b0}}) && push_ok_s;
        write_mem_s    = push_ok_s && !load_din_s;
        mem_cnt_next_s = mem_cnt_r + CNT_W'(write_mem_s) - CNT_W'(load_mem_s);
        level_next_s   = level_r + LEVEL_W'(push_ok_s) - LEVEL_W'(pop_ok_s);
    end

    // Backing array write port. The array holds no state that needs resetting.
    always_ff @(posedge clock) begin
        if (write_mem_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy, flags and the registered head.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_r  <= {PTR_W{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            mem_cnt_r <= {CNT_W{1'b0}};
            level_r   <= {LEVEL_W{1'b0}};
            head_r    <= {W{1'b0}};
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
        end else begin
            rd_ptr_r  <= rd_ptr_r + PTR_W'(load_mem_s);
            wr_ptr_r  <= wr_ptr_r + PTR_W'(write_mem_s);
            mem_cnt_r <= mem_cnt_next_s;
            level_r   <= level_next_s;
            full_r    <= (level_next_s == LEVEL_W'(DEPTH));
            if (load_mem_s) begin
                head_r  <= mem_r[rd_ptr_r];
                empty_r <= 1'b0;
            end else if (load_din_s) begin
                head_r  <= din;
                empty_r <= 1'b0;
            end else if (pop_ok_s) begin
                empty_r <= 1'b1;
            end
        end
    end

    assign head  = head_r;
    assign level = level_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/dot_update_queue.sv
// dot_update_queue: decodes processor data-memory writes to the dot MMIO
// window into {is_y, id, clamped loc} updates. It queues the updates in
// arrival order for the VGA side and counts writes dropped on overflow.
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   mem_wren/addr/data    : processor data-memory write port
//   upd_valid/upd_ready   : head handshake toward the VGA consumer
//   upd_is_y/upd_id/upd_loc : head entry fields (registered)
//   level                 : queue occupancy 0..DEPTH
//   overflow, drop_count  : sticky drop flag and saturating drop counter
module dot_update_queue
    import dot_update_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LOC_W = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mem_wren,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_data,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic               upd_is_y,
    output logic [ID_W-1:0]    upd_id,
    output logic [LOC_W-1:0]   upd_loc,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic [7:0]         drop_count
);

    localparam int ENTRY_W = 1 + ID_W + LOC_W;

    logic               push_req_s;
    logic               is_y_s;
    logic [ID_W-1:0]    id_s;
    logic [LOC_W-1:0]   loc_s;
    logic               drop_s;
    logic [ENTRY_W-1:0] head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               overflow_r;
    logic [7:0]         drop_count_r;

    // Address decode and coordinate clamp for the incoming write.
    always_comb begin
        push_req_s = 1'b0;
        is_y_s     = 1'b0;
        id_s       = {ID_W{1'b0}};
        loc_s      = {LOC_W{1'b0}};
        case (decode_addr(mem_addr))
            DEC_X: begin
                push_req_s = mem_wren;
                is_y_s     = 1'b0;
                id_s       = ID_W'(mem_addr - X_BASE);
                loc_s      = LOC_W'(clamp_coord(mem_data, X_MAX));
            end
            DEC_Y: begin
                push_req_s = mem_wren;
                is_y_s     = 1'b1;
                id_s       = ID_W'(mem_addr - Y_BASE);
                loc_s      = LOC_W'(clamp_coord(mem_data, Y_MAX));
            end
            default: begin
                push_req_s = 1'b0;
            end
        endcase
    end

    // A write is lost only when the queue is full and the head is not leaving.
    assign drop_s = push_req_s && fifo_full_s && !(upd_valid && upd_ready);

    dot_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req_s),
        .din   ({is_y_s, id_s, loc_s}),
        .pop   (upd_ready),
        .head  (head_s),
        .level (level),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sticky overflow flag and saturating drop counter. Only reset clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_count_r != 8'hFF) begin
                drop_count_r <= drop_count_r + 8'd1;
            end
        end
    end

    assign upd_valid  = ~fifo_empty_s;
    assign upd_is_y   = head_s[ENTRY_W-1];
    assign upd_id     = head_s[ENTRY_W-2 -: ID_W];
    assign upd_loc    = head_s[LOC_W-1:0];
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_dot_update_queue.sv
module tb_dot_update_queue;

    typedef logic [20:0] ent_t;

    logic        clock;
    logic        reset;
    int          checks;
    int          errors;

    // DEPTH 16 instance for directed scenarios
    logic        a_wren, a_ready, a_valid, a_is_y, a_ovf;
    logic [31:0] a_addr, a_data;
    logic [9:0]  a_id, a_loc;
    logic [6:0]  a_level;
    logic [7:0]  a_drops;

    // DEPTH 4 instance for the randomized scoreboard run
    logic        b_wren, b_ready, b_valid, b_is_y, b_ovf;
    logic [31:0] b_addr, b_data;
    logic [9:0]  b_id, b_loc;
    logic [6:0]  b_level;
    logic [7:0]  b_drops;

    // reference model state for the DEPTH 4 instance
    ent_t        mq[$];
    int          m_drops;
    bit          m_ovf;

    dot_update_queue #(.DEPTH(16), .LOC_W(10)) u16 (
        .clock(clock), .reset(reset), .mem_wren(a_wren), .mem_addr(a_addr),
        .mem_data(a_data), .upd_valid(a_valid), .upd_ready(a_ready),
        .upd_is_y(a_is_y), .upd_id(a_id), .upd_loc(a_loc), .level(a_level),
        .overflow(a_ovf), .drop_count(a_drops));

    dot_update_queue #(.DEPTH(4), .LOC_W(10)) u4 (
        .clock(clock), .reset(reset), .mem_wren(b_wren), .mem_addr(b_addr),
        .mem_data(b_data), .upd_valid(b_valid), .upd_ready(b_ready),
        .upd_is_y(b_is_y), .upd_id(b_id), .upd_loc(b_loc), .level(b_level),
        .overflow(b_ovf), .drop_count(b_drops));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive_a(input logic w, input logic [31:0] ad,
                           input logic [31:0] d, input logic r);
        @(negedge clock);
        a_wren = w; a_addr = ad; a_data = d; a_ready = r;
        @(posedge clock);
        #1;
    endtask

    // Model entry for a write: returns 1 and the entry when it is a dot update.
    function automatic bit model_decode(input logic [31:0] ad, input logic [31:0] d,
                                        output ent_t e);
        longint unsigned a, v, loc;
        a = ad; v = d;
        e = 21'd0;
        if (a >= 100 && a <= 549) begin
            loc = (v > 639) ? 639 : v;
            e = {1'b0, 10'(a - 100), 10'(loc)};
            return 1'b1;
        end
        if (a >= 550 && a <= 999) begin
            loc = (v > 479) ? 479 : v;
            e = {1'b1, 10'(a - 550), 10'(loc)};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance the queue model by one clock edge, depth 4.
    task automatic model_step(input logic w, input logic [31:0] ad,
                              input logic [31:0] d, input logic r);
        ent_t e;
        bit   is_upd, popping, was_full;
        is_upd   = model_decode(ad, d, e) && w;
        popping  = r && (mq.size() > 0);
        was_full = (mq.size() == 4);
        if (popping) void'(mq.pop_front());
        if (is_upd) begin
            if (was_full && !popping) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end else begin
                mq.push_back(e);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++;
        if (a_valid !== 1'b0 || a_is_y !== 1'b0 || a_id !== 10'd0 || a_loc !== 10'd0) begin
            errors++;
            $display("FAIL reset_head: valid=%b is_y=%b id=%0d loc=%0d required all 0",
                     a_valid, a_is_y, a_id, a_loc);
        end
        checks++;
        if (a_level !== 7'd0 || a_ovf !== 1'b0 || a_drops !== 8'd0) begin
            errors++;
            $display("FAIL reset_status: level=%0d ovf=%b drops=%0d required 0/0/0",
                     a_level, a_ovf, a_drops);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        drive_a(1'b1, 32'd100, 32'd37, 1'b1);
        checks++;
        if (a_valid !== 1'b1 || a_is_y !== 1'b0 || a_id !== 10'd0 || a_loc !== 10'd37) begin
            errors++;
            $display("FAIL basic_x: valid=%b is_y=%b id=%0d loc=%0d required 1/0/0/37",
                     a_valid, a_is_y, a_id, a_loc);
        end
        drive_a(1'b1, 32'd550, 32'd200, 1'b1);
        checks++;
        if (a_valid !== 1'b1 || a_is_y !== 1'b1 || a_id !== 10'd0 || a_loc !== 10'd200) begin
            errors++;
            $display("FAIL basic_y: valid=%b is_y=%b id=%0d loc=%0d required 1/1/0/200",
                     a_valid, a_is_y, a_id, a_loc);
        end
        drive_a(1'b0, 32'd0, 32'd0, 1'b1);
        checks++;
        if (a_valid !== 1'b0 || a_level !== 7'd0) begin
            errors++;
            $display("FAIL basic_drain: valid=%b level=%0d required 0/0", a_valid, a_level);
        end
    endtask

    task automatic test_clamp_bounds;
        drive_a(1'b1, 32'd549, 32'd5000, 1'b0);
        drive_a(1'b1, 32'd999, 32'd700, 1'b0);
        drive_a(1'b1, 32'd99, 32'd1, 1'b0);
        drive_a(1'b1, 32'd1000, 32'd1, 1'b0);
        drive_a(1'b0, 32'd100, 32'd1, 1'b0);
        checks++;
        if (a_level !== 7'd2 || a_drops !== 8'd0) begin
            errors++;
            $display("FAIL bounds_level: level=%0d drops=%0d required 2/0", a_level, a_drops);
        end
        checks++;
        if (a_valid !== 1'b1 || a_is_y !== 1'b0 || a_id !== 10'd449 || a_loc !== 10'd639) begin
            errors++;
            $display("FAIL clamp_x: valid=%b is_y=%b id=%0d loc=%0d required 1/0/449/639",
                     a_valid, a_is_y, a_id, a_loc);
        end
        drive_a(1'b0, 32'd0, 32'd0, 1'b1);
        checks++;
        if (a_valid !== 1'b1 || a_is_y !== 1'b1 || a_id !== 10'd449 || a_loc !== 10'd479) begin
            errors++;
            $display("FAIL clamp_y: valid=%b is_y=%b id=%0d loc=%0d required 1/1/449/479",
                     a_valid, a_is_y, a_id, a_loc);
        end
        drive_a(1'b0, 32'd0, 32'd0, 1'b1);
        checks++;
        if (a_valid !== 1'b0 || a_level !== 7'd0) begin
            errors++;
            $display("FAIL bounds_drain: valid=%b level=%0d required 0/0", a_valid, a_level);
        end
    endtask

    task automatic test_overflow_full;
        int exp_id;
        for (int i = 0; i < 18; i++) drive_a(1'b1, 32'(100 + i), 32'(i), 1'b0);
        checks++;
        if (a_level !== 7'd16 || a_ovf !== 1'b1 || a_drops !== 8'd2) begin
            errors++;
            $display("FAIL overflow_state: level=%0d ovf=%b drops=%0d required 16/1/2",
                     a_level, a_ovf, a_drops);
        end
        checks++;
        if (a_valid !== 1'b1 || a_id !== 10'd0) begin
            errors++;
            $display("FAIL overflow_head: valid=%b id=%0d required 1/0", a_valid, a_id);
        end
        // push and pop together while full
        drive_a(1'b1, 32'd120, 32'd20, 1'b1);
        checks++;
        if (a_level !== 7'd16 || a_drops !== 8'd2 || a_id !== 10'd1) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d drops=%0d head=%0d required 16/2/1",
                     a_level, a_drops, a_id);
        end
        for (int k = 0; k < 16; k++) begin
            exp_id = (k < 15) ? k + 1 : 20;
            checks++;
            if (a_valid !== 1'b1 || a_id !== 10'(exp_id) || a_loc !== 10'(exp_id) || a_is_y !== 1'b0) begin
                errors++;
                $display("FAIL drain_order[%0d]: valid=%b id=%0d loc=%0d required id=loc=%0d",
                         k, a_valid, a_id, a_loc, exp_id);
            end
            drive_a(1'b0, 32'd0, 32'd0, 1'b1);
        end
        checks++;
        if (a_valid !== 1'b0 || a_level !== 7'd0 || a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: valid=%b level=%0d ovf=%b required 0/0/1",
                     a_valid, a_level, a_ovf);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) drive_a(1'b1, 32'(100 + i), 32'(i + 50), 1'b0);
        checks++;
        if (a_level !== 7'd5) begin
            errors++;
            $display("FAIL mid_level: level=%0d required 5", a_level);
        end
        @(negedge clock);
        reset = 1'b1; a_wren = 1'b1; a_addr = 32'd100; a_data = 32'd9; a_ready = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_level !== 7'd0 || a_ovf !== 1'b0 || a_drops !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b level=%0d ovf=%b drops=%0d required 0/0/0/0",
                     a_valid, a_level, a_ovf, a_drops);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (a_valid !== 1'b0 || a_level !== 7'd0) begin
            errors++;
            $display("FAIL write_in_reset: valid=%b level=%0d required 0/0", a_valid, a_level);
        end
        reset = 1'b0; a_addr = 32'd107; a_data = 32'd3;
        @(posedge clock);
        #1;
        checks++;
        if (a_valid !== 1'b1 || a_id !== 10'd7 || a_loc !== 10'd3 || a_level !== 7'd1) begin
            errors++;
            $display("FAIL post_reset_push: valid=%b id=%0d loc=%0d level=%0d required 1/7/3/1",
                     a_valid, a_id, a_loc, a_level);
        end
        drive_a(1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    task automatic test_random_depth4;
        logic        w, r;
        logic [31:0] ad, d;
        int          sel;
        @(negedge clock);
        reset = 1'b1;
        b_wren = 1'b0; b_ready = 1'b0;
        mq.delete(); m_drops = 0; m_ovf = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n < 300) begin
                w   = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 9);
                if (sel < 4)       ad = 32'(100 + $urandom_range(0, 449));
                else if (sel < 8)  ad = 32'(550 + $urandom_range(0, 449));
                else if (sel == 8) ad = ($urandom_range(0, 1) == 1) ? 32'd99 : 32'd1000;
                else               ad = $urandom;
                d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1000)) : $urandom;
                r = ($urandom_range(0, 2) == 0);
            end else begin
                // sustained overflow: valid writes, consumer stalled
                w  = 1'b1;
                ad = 32'(100 + $urandom_range(0, 449));
                d  = $urandom;
                r  = 1'b0;
            end
            @(negedge clock);
            b_wren = w; b_addr = ad; b_data = d; b_ready = r;
            @(posedge clock);
            model_step(w, ad, d, r);
            #1;
            checks++;
            if (b_valid !== (mq.size() > 0)) begin
                errors++;
                $display("FAIL rnd_valid[%0d]: valid=%b required %0d", n, b_valid, mq.size() > 0);
            end else if (mq.size() > 0 && {b_is_y, b_id, b_loc} !== mq[0]) begin
                errors++;
                $display("FAIL rnd_head[%0d]: head=%h required %h", n, {b_is_y, b_id, b_loc}, mq[0]);
            end
            checks++;
            if (b_level !== 7'(mq.size()) || b_level > 7'd4) begin
                errors++;
                $display("FAIL rnd_level[%0d]: level=%0d required %0d", n, b_level, mq.size());
            end
            checks++;
            if (b_drops !== 8'(m_drops) || b_ovf !== m_ovf) begin
                errors++;
                $display("FAIL rnd_drops[%0d]: drops=%0d ovf=%b required %0d/%b",
                         n, b_drops, b_ovf, m_drops, m_ovf);
            end
        end
        checks++;
        if (b_drops !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate: drops=%0d required 255", b_drops);
        end
        b_wren = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        a_wren = 1'b0; a_addr = 32'd0; a_data = 32'd0; a_ready = 1'b0;
        b_wren = 1'b0; b_addr = 32'd0; b_data = 32'd0; b_ready = 1'b0;
        m_drops = 0; m_ovf = 1'b0;
        test_reset;
        test_basic;
        test_clamp_bounds;
        test_overflow_full;
        test_reset_mid;
        test_random_depth4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_update_queue.md
DOT_UPDATE_QUEUE -- requirements
Module: dot_update_queue

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entries (power of two, 4..64).
REQ-002 Parameter LOC_W, default 10, meaning stored coordinate width.
REQ-003 Port clock  in  1  single clock, rising-edge; sole clock of the block.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port mem_wren  in  1  processor data-memory write enable.
REQ-006 Port mem_addr  in  32  processor data-memory word address.
REQ-007 Port mem_data  in  32  processor write data (dot coordinate).
REQ-008 Port upd_valid  out  1  queue head holds a dot update.
REQ-009 Port upd_ready  in  1  VGA-side consumer accepts head.
REQ-010 Port upd_is_y  out  1  head is a Y coordinate (0 = X).
REQ-011 Port upd_id  out  10  dot index 0..449.
REQ-012 Port upd_loc  out  LOC_W  clamped coordinate.
REQ-013 Port level  out  7  current occupancy 0..DEPTH.
REQ-014 Port overflow  out  1  sticky: at least one write dropped.
REQ-015 Port drop_count  out  8  dropped writes, saturating at 255.

Function
REQ-016 Decode SHALL be: X write when mem_wren and 100 <= mem_addr <= 549 (id = addr-100); Y write when mem_wren and 550 <= mem_addr <= 999 (id = addr-550); all other writes ignored.
REQ-017 Clamp SHALL be: X loc = min(mem_data, 639), Y loc = min(mem_data, 479), mem_data treated unsigned 32-bit before truncation to LOC_W.
REQ-018 A decoded write SHALL be pushed {is_y, id, loc} at the rising edge it is presented; upd_valid SHALL rise on the next cycle when queue was empty (latency 1).
REQ-019 Handshake SHALL transfer the head on a cycle where upd_valid && upd_ready; outputs SHALL hold stable while upd_valid && !upd_ready.
REQ-020 Entries SHALL leave in strict arrival order; no coalescing.
REQ-021 Push when level == DEPTH and no pop that cycle SHALL drop the write, set overflow, increment drop_count (saturating at 255); queue contents unchanged.
REQ-022 Push and pop in the same cycle when full SHALL both succeed; level unchanged, nothing dropped.
REQ-023 Push and pop in the same cycle when empty SHALL not bypass; entry appears at head next cycle.
REQ-024 Pointers SHALL wrap modulo DEPTH; level SHALL be exact across wrap.
REQ-025 upd_is_y/upd_id/upd_loc SHALL be don't-care while upd_valid == 0, but driven to 0 after reset.
REQ-026 overflow and drop_count SHALL clear only on reset.

Reset
REQ-027 Reset assertion SHALL asynchronously clear pointers, level, overflow, drop_count, upd_valid and all upd_* outputs to 0.
REQ-028 Reset mid-operation SHALL discard all queued entries; a write presented during reset SHALL be ignored.
REQ-029 First push SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-030 Shared package SHALL hold X_BASE=100, Y_BASE=550, MMIO_END=999, DOT_COUNT=450, X_MAX=639, Y_MAX=479, ID_W=10.
REQ-031 Storage SHALL be a sub-module dot_fifo (synchronous FIFO, registered head, level/full/empty outputs); decode, clamp and drop accounting SHALL live in the top.
REQ-032 No combinational path SHALL exist from mem_* inputs to upd_* outputs.

Verification
REQ-033 Write addr 100 data 37, then addr 550 data 200, upd_ready=1 -> cycle+1: X id0 loc37; next: Y id0 loc200.
REQ-034 Write addr 549 data 5000 and addr 999 data 700 -> X id449 loc639, Y id449 loc479; writes to 99 and 1000 -> no push.
REQ-035 upd_ready=0, 18 writes, DEPTH 16 -> level 16, overflow=1, drop_count=2; drain -> first 16 in order.
REQ-036 Full queue, upd_ready=1 plus write same cycle -> level stays 16, drop_count unchanged.
REQ-037 Assert reset with 5 queued -> upd_valid=0, level=0, overflow=0 immediately; post-reset write appears one cycle later.
REQ-038 300 writes with random upd_ready, DEPTH 4 -> scoreboard order/content match, level never exceeds 4, drop_count saturates at 255 under sustained overflow.
